hazard_ctrl: RTL

- Central hazard and sequencing controller for the 5-stage pipeline.
- Drives the stall and flush enables of the fetch, decode, execute, memory and writeback pipeline registers, and the forwarding selects of the execute-stage operand muxes.
- Resolves load-use hazards, taken-branch redirects and multi-cycle data-memory waits.
- Contains a small FSM and a wait-timeout counter.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/fwd_sel.sv | 32 +++
 rtl/hazard_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Forward-select encodings, FSM states and default widths.
package hazard_pkg;

  localparam int HZ_REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/fwd_sel.sv
// M/W forwarding comparator for one execute-stage operand.
// M wins over W; x0 never forwards.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = HZ_REG_ADDR_WIDTH
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [REG_ADDR_WIDTH-1:0] rdm,
  input  logic [REG_ADDR_WIDTH-1:0] rdw,
  input  logic                      regwritem,
  input  logic                      regwritew,
  output fwd_sel_t                  sel
);

  logic hitm;
  logic hitw;

  assign hitm = regwritem && (rdm != '0) && (rdm == rs);
  assign hitw = regwritew && (rdw != '0) && (rdw == rs) && !hitm;

  // pick the youngest producer that matches the operand
  always_comb begin
    sel = FWD_RF;
    unique case (1'b1)
      hitm:    sel = FWD_M;
      hitw:    sel = FWD_W;
      default: sel = FWD_RF;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush/forward controller for the 5-stage pipe.
// Optional perf counters: define HAZARD_PERF_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = HZ_REG_ADDR_WIDTH,
  parameter int MEM_TIMEOUT    = 64,
  parameter int PERF_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] rs1d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2d,
  input  logic [REG_ADDR_WIDTH-1:0] rs1e,
  input  logic [REG_ADDR_WIDTH-1:0] rs2e,
  input  logic [REG_ADDR_WIDTH-1:0] rde,
  input  logic [REG_ADDR_WIDTH-1:0] rdm,
  input  logic [REG_ADDR_WIDTH-1:0] rdw,
  input  logic                      loade,
  input  logic                      regwritem,
  input  logic                      regwritew,
  input  logic                      pcsrce,
  input  logic                      memreqm,
  input  logic                      memreadym,
  output logic                      stallf,
  output logic                      stalld,
  output logic                      stalle,
  output logic                      stallm,
  output logic                      flushd,
  output logic                      flushe,
  output logic                      flushw,
  output logic [1:0]                forwardae,
  output logic [1:0]                forwardbe,
  output logic                      memtimeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0]     stallcnt,
  output logic [PERF_WIDTH-1:0]     flushcnt
`endif
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(MEM_TIMEOUT);

  hz_state_t      state;
  hz_state_t      state_n;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_n;
  logic           to_n;
  fwd_sel_t       fa;
  fwd_sel_t       fb;
  logic           luse;
  logic           memstall;
  logic           br;
  logic           lu;

  fwd_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs        (rs1e),
    .rdm       (rdm),
    .rdw       (rdw),
    .regwritem (regwritem),
    .regwritew (regwritew),
    .sel       (fa)
  );

  fwd_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs        (rs2e),
    .rdm       (rdm),
    .rdw       (rdw),
    .regwritem (regwritem),
    .regwritew (regwritew),
    .sel       (fb)
  );

  assign forwardae = rst_n ? fa : FWD_RF;
  assign forwardbe = rst_n ? fb : FWD_RF;

  // branch beats load-use: the D instruction is wrong-path
  assign luse     = loade && (rde != '0) &&
                    ((rde == rs1d) || (rde == rs2d));
  assign memstall = memreqm && !memreadym;
  assign br       = pcsrce && !memstall;
  assign lu       = luse && !pcsrce && !memstall;

  // next state, wait counter and stall/flush decode
  always_comb begin
    stallf  = 1'b0;
    stalld  = 1'b0;
    stalle  = 1'b0;
    stallm  = 1'b0;
    flushd  = 1'b0;
    flushe  = 1'b0;
    flushw  = 1'b0;
    state_n = state;
    cnt_n   = cnt;
    to_n    = memtimeout;
    if (!rst_n) begin
      flushd  = 1'b1;
      flushe  = 1'b1;
      flushw  = 1'b1;
      state_n = RUN;
      cnt_n   = '0;
      to_n    = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          unique case (1'b1)
            memstall: begin
              stallf  = 1'b1;
              stalld  = 1'b1;
              stalle  = 1'b1;
              stallm  = 1'b1;
              flushw  = 1'b1;
              state_n = MEM_WAIT;
              cnt_n   = CW'(1);
            end
            br: begin
              flushd = 1'b1;
              flushe = 1'b1;
            end
            lu: begin
              stallf = 1'b1;
              stalld = 1'b1;
              flushe = 1'b1;
            end
            default: ;
          endcase
        end
        MEM_WAIT: begin
          if (memreadym) begin
            state_n = RUN;
            cnt_n   = '0;
          end else begin
            stallf = 1'b1;
            stalld = 1'b1;
            stalle = 1'b1;
            stallm = 1'b1;
            flushw = 1'b1;
            cnt_n  = (cnt == TMAX) ? TMAX : cnt + 1'b1;
          end
        end
        default: state_n = RUN;
      endcase
      if ((state_n == MEM_WAIT) && (cnt_n == TMAX)) begin
        to_n = 1'b1;
      end
    end
  end

  // state, counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      cnt        <= '0;
      memtimeout <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      memtimeout <= to_n;
    end
  end

`ifdef HAZARD_PERF_EN
  // saturating stall and flush event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stallcnt <= '0;
      flushcnt <= '0;
    end else begin
      if (stallf && !(&stallcnt)) begin
        stallcnt <= stallcnt + 1'b1;
      end
      if (flushe && !(&flushcnt)) begin
        flushcnt <= flushcnt + 1'b1;
      end
    end
  end
`endif

endmodule
